bp_be_late_wb_buffer: RTL and testbench
=======================================

Name: bp_be_late_wb_buffer

Overview:
- Buffers long-latency writebacks from two sources: source 0 is the integer long-latency unit (idiv/mul-long); source 1 is the dcache late-load/PTW return path.
- Presents the buffered writebacks one at a time, in order, on the scheduler's late-writeback handshake (pkt/v/force/yumi).
- Produces per-register pending masks for hazard detection.
- Sits directly upstream of the scheduler's late-writeback input.

Parameters:
- els_p, 4, buffer depth in entries; must be >= 2.
- age_limit_p, 8, number of cycles the head entry may wait before force is asserted; must be >= 1.
- dword_width_p, 64, writeback data width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- src0_v_i  in  1  source 0 writeback valid.
- src0_ready_and_o  out  1  source 0 may enqueue.
- src0_rd_addr_i  in  5  destination register.
- src0_ird_w_v_i  in  1  integer RF write.
- src0_frd_w_v_i  in  1  FP RF write.
- src0_ptw_w_v_i  in  1  PTW data return.
- src0_data_i  in  dword_width_p  writeback data.
- src0_fflags_i  in  5  FP exception flags.
- src1_*  (same set of fields as src0_*)  source 1.
- late_wb_v_o  out  1  head entry valid.
- late_wb_force_o  out  1  scheduler must accept this cycle.
- late_wb_yumi_i  in  1  scheduler consumes the head.
- late_wb_rd_addr_o, late_wb_ird_w_v_o, late_wb_frd_w_v_o, late_wb_ptw_w_v_o, late_wb_data_o, late_wb_fflags_o  out  (widths as the matching inputs)  head entry fields.
- irf_pending_o  out  32  integer registers with a buffered writeback.
- frf_pending_o  out  32  FP registers with a buffered writeback.

Behaviour:
- Reset:
  - One clock domain.
  - Reset is asynchronous and active-low: reset_n_i low immediately clears the count, read/write pointers, all entry valid bits and the age counter.
  - While reset_n_i is low, both ready outputs, late_wb_v_o, late_wb_force_o and both pending masks are 0.
  - All late_wb_* data outputs are forced to 0 whenever late_wb_v_o=0, including during reset.
- Storage: circular FIFO with a count register of $clog2(els_p+1) bits. Pointers wrap modulo els_p; els_p is not required to be a power of two.
- Readiness (computed from the registered count and same-cycle valids, never from yumi):
  - src1_ready_and_o = count < els_p.
  - src0_ready_and_o = (count < els_p-1) | (count == els_p-1 & ~src1_v_i).
- Enqueue:
  - A source enqueues when its v & ready are both high.
  - If both sources enqueue in the same cycle, src1 is written first at wptr and src0 at wptr+1.
  - count += number enqueued − dequeued.
- Output latency:
  - An entry is visible on the outputs the cycle after enqueue; there is no bypass.
  - The head fields are driven from rptr.
- Dequeue:
  - The head is dequeued on late_wb_yumi_i & late_wb_v_o, and rptr advances.
  - Yumi while late_wb_v_o=0 is illegal; it is ignored, and an assertion fires.
  - Dequeue and enqueue in the same cycle are both honoured.
  - Readiness does not credit the same-cycle dequeue, so a full buffer accepts again the cycle after a yumi.
- Age:
  - The age counter has $clog2(age_limit_p+1) bits.
  - It resets to 0 when the head changes (a dequeue, or an enqueue into an empty buffer).
  - It increments, saturating at age_limit_p, each cycle the head is valid and not yumi'd.
- Force:
  - late_wb_force_o = late_wb_v_o & (count == els_p | age == age_limit_p).
  - Force is registered-state-only and does not depend on same-cycle inputs.
- Pending masks:
  - irf_pending_o[r] = OR over valid entries of (ird_w_v & rd_addr == r).
  - irf_pending_o[0] is always 0.
  - frf_pending_o is formed the same way from frd_w_v, including f0.
  - Multiple entries targeting the same register are permitted; a bit clears only when no valid entry targets that register.
  - Masks reflect only registered entries, so an enqueue shows in the masks next cycle.
- Order: in-order only; there is no reordering or merging of entries.
- PTW entries (ptw_w_v) are stored and forwarded identically to other entries.
- Reset mid-operation: all entries are lost. Sources must re-issue them, and system reset guarantees this.

Test Plan:
- Single enqueue: src0 enqueues x5 ← 0x1234 in cycle N → late_wb_v_o=1 in N+1 with rd_addr=5, data=0x1234; irf_pending_o=0x20 in N+1; yumi in N+1 → v=0 and mask=0 in N+2.
- Dual enqueue: src0 (x3) and src1 (f7) valid together into an empty buffer → outputs show f7 first, then x3; count=2; irf_pending_o=0x8; frf_pending_o=0x80.
- Full/backpressure: 4 entries queued with no yumi → both readies 0 and late_wb_force_o=1; one yumi → readies return next cycle.
- At count=3 (els_p=4) with both sources valid → only src1 is accepted; src0_ready_and_o=0.
- Aging: one entry held without yumi → force rises on cycle 8 after the entry becomes visible; yumi → age and force return to 0.
- x0 and duplicates:
  - An entry to x0 with ird_w_v → irf_pending_o[0]=0.
  - Two entries to x9 → bit 9 stays set after the first dequeue and clears after the second.
- Async reset: assert reset_n_i mid-cycle with 3 entries held → outputs and masks go to 0 before the next clk edge; after release, readies=1 and v=0.

Source files
------------

// File: rtl/bp_be_late_wb_buffer.sv
// bp_be_late_wb_buffer: in-order two-source late-writeback FIFO with head aging/force and RF pending masks.
// Revision 1.0
`default_nettype none

module bp_be_late_wb_buffer #(
  parameter int els_p         = 4,
  parameter int age_limit_p   = 8,
  parameter int dword_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     src0_v_i,
  output logic                     src0_ready_and_o,
  input  logic [4:0]               src0_rd_addr_i,
  input  logic                     src0_ird_w_v_i,
  input  logic                     src0_frd_w_v_i,
  input  logic                     src0_ptw_w_v_i,
  input  logic [dword_width_p-1:0] src0_data_i,
  input  logic [4:0]               src0_fflags_i,

  input  logic                     src1_v_i,
  output logic                     src1_ready_and_o,
  input  logic [4:0]               src1_rd_addr_i,
  input  logic                     src1_ird_w_v_i,
  input  logic                     src1_frd_w_v_i,
  input  logic                     src1_ptw_w_v_i,
  input  logic [dword_width_p-1:0] src1_data_i,
  input  logic [4:0]               src1_fflags_i,

  output logic                     late_wb_v_o,
  output logic                     late_wb_force_o,
  input  logic                     late_wb_yumi_i,
  output logic [4:0]               late_wb_rd_addr_o,
  output logic                     late_wb_ird_w_v_o,
  output logic                     late_wb_frd_w_v_o,
  output logic                     late_wb_ptw_w_v_o,
  output logic [dword_width_p-1:0] late_wb_data_o,
  output logic [4:0]               late_wb_fflags_o,

  output logic [31:0]              irf_pending_o,
  output logic [31:0]              frf_pending_o
);

  localparam int c_cnt_w = $clog2(els_p + 1);
  localparam int c_ptr_w = $clog2(els_p);
  localparam int c_age_w = $clog2(age_limit_p + 1);

  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(els_p);
  localparam logic [c_cnt_w-1:0] c_almost  = c_cnt_w'(els_p - 1);
  localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(els_p - 1);
  localparam logic [c_age_w-1:0] c_age_max = c_age_w'(age_limit_p);

  typedef struct packed {
    logic [4:0]               rd_addr;
    logic                     ird_w_v;
    logic                     frd_w_v;
    logic                     ptw_w_v;
    logic [dword_width_p-1:0] data;
    logic [4:0]               fflags;
  } entry_t;

  entry_t               r_mem [els_p];
  logic [els_p-1:0]     r_valid;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_age_w-1:0]   r_age;

  entry_t               w_src0_entry;
  entry_t               w_src1_entry;
  entry_t               w_head;
  logic                 w_head_v;
  logic                 w_enq0;
  logic                 w_enq1;
  logic                 w_deq;
  logic [c_ptr_w-1:0]   w_wptr_p1;
  logic [c_ptr_w-1:0]   w_wptr_p2;
  logic [c_ptr_w-1:0]   w_slot0;
  logic [31:0]          w_irf_pending;
  logic [31:0]          w_frf_pending;

  // Pointers wrap explicitly so els_p need not be a power of two.
  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  assign w_src0_entry = '{rd_addr: src0_rd_addr_i, ird_w_v: src0_ird_w_v_i,
                          frd_w_v: src0_frd_w_v_i, ptw_w_v: src0_ptw_w_v_i,
                          data: src0_data_i, fflags: src0_fflags_i};
  assign w_src1_entry = '{rd_addr: src1_rd_addr_i, ird_w_v: src1_ird_w_v_i,
                          frd_w_v: src1_frd_w_v_i, ptw_w_v: src1_ptw_w_v_i,
                          data: src1_data_i, fflags: src1_fflags_i};

  // src1 has priority for the last free slot; yumi is deliberately not credited.
  assign src1_ready_and_o = reset_n_i & (r_count < c_full);
  assign src0_ready_and_o = reset_n_i & ((r_count < c_almost) |
                                         ((r_count == c_almost) & ~src1_v_i));

  assign w_enq1    = src1_v_i & src1_ready_and_o;
  assign w_enq0    = src0_v_i & src0_ready_and_o;
  assign w_head_v  = r_valid[r_rptr];
  assign w_deq     = late_wb_yumi_i & w_head_v;
  assign w_wptr_p1 = f_inc(r_wptr);
  assign w_wptr_p2 = f_inc(w_wptr_p1);
  assign w_slot0   = w_enq1 ? w_wptr_p1 : r_wptr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_age   <= '0;
    end else begin
      r_count <= r_count + c_cnt_w'(w_enq0) + c_cnt_w'(w_enq1) - c_cnt_w'(w_deq);
      if (w_deq) begin
        r_rptr <= f_inc(r_rptr);
      end
      if (w_enq0 & w_enq1) begin
        r_wptr <= w_wptr_p2;
      end else if (w_enq0 | w_enq1) begin
        r_wptr <= w_wptr_p1;
      end
      // An enqueue slot never aliases the dequeued slot: full blocks enqueue, empty blocks dequeue.
      for (int i = 0; i < els_p; i++) begin
        if (w_deq && (r_rptr == c_ptr_w'(i))) begin
          r_valid[i] <= 1'b0;
        end
        if ((w_enq1 && (r_wptr == c_ptr_w'(i))) || (w_enq0 && (w_slot0 == c_ptr_w'(i)))) begin
          r_valid[i] <= 1'b1;
        end
      end
      if (w_deq || (!w_head_v && (w_enq0 || w_enq1))) begin
        r_age <= '0;
      end else if (w_head_v && (r_age != c_age_max)) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (w_enq1 && (r_wptr == c_ptr_w'(i))) begin
        r_mem[i] <= w_src1_entry;
      end else if (w_enq0 && (w_slot0 == c_ptr_w'(i))) begin
        r_mem[i] <= w_src0_entry;
      end
    end
  end

  assign w_head = w_head_v ? r_mem[r_rptr] : '0;

  assign late_wb_v_o       = w_head_v;
  assign late_wb_force_o   = w_head_v & ((r_count == c_full) | (r_age == c_age_max));
  assign late_wb_rd_addr_o = w_head.rd_addr;
  assign late_wb_ird_w_v_o = w_head.ird_w_v;
  assign late_wb_frd_w_v_o = w_head.frd_w_v;
  assign late_wb_ptw_w_v_o = w_head.ptw_w_v;
  assign late_wb_data_o    = w_head.data;
  assign late_wb_fflags_o  = w_head.fflags;

  always_comb begin
    w_irf_pending = '0;
    w_frf_pending = '0;
    for (int i = 0; i < els_p; i++) begin
      if (r_valid[i]) begin
        if (r_mem[i].ird_w_v) begin
          w_irf_pending[r_mem[i].rd_addr] = 1'b1;
        end
        if (r_mem[i].frd_w_v) begin
          w_frf_pending[r_mem[i].rd_addr] = 1'b1;
        end
      end
    end
    // x0 is hardwired zero and never a hazard.
    w_irf_pending[0] = 1'b0;
  end

  assign irf_pending_o = w_irf_pending;
  assign frf_pending_o = w_frf_pending;

  a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                         late_wb_yumi_i |-> w_head_v);

endmodule

`default_nettype wire

// File: tb/tb_bp_be_late_wb_buffer.sv
// tb_bp_be_late_wb_buffer: directed stimulus with a scoreboard queue checked by an output monitor.
// Revision 1.0
`default_nettype none

module tb_bp_be_late_wb_buffer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        src0_v_i, src0_ready_and_o, src0_ird_w_v_i, src0_frd_w_v_i, src0_ptw_w_v_i;
  logic [4:0]  src0_rd_addr_i, src0_fflags_i;
  logic [63:0] src0_data_i;
  logic        src1_v_i, src1_ready_and_o, src1_ird_w_v_i, src1_frd_w_v_i, src1_ptw_w_v_i;
  logic [4:0]  src1_rd_addr_i, src1_fflags_i;
  logic [63:0] src1_data_i;
  logic        late_wb_v_o, late_wb_force_o, late_wb_yumi_i;
  logic [4:0]  late_wb_rd_addr_o, late_wb_fflags_o;
  logic        late_wb_ird_w_v_o, late_wb_frd_w_v_o, late_wb_ptw_w_v_o;
  logic [63:0] late_wb_data_o;
  logic [31:0] irf_pending_o, frf_pending_o;

  typedef struct packed {
    logic [4:0]  rd;
    logic        ird;
    logic        frd;
    logic        ptw;
    logic [63:0] data;
    logic [4:0]  ff;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_act, mon_exp;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  bp_be_late_wb_buffer #(.els_p(4), .age_limit_p(8), .dword_width_p(64)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .src0_v_i(src0_v_i), .src0_ready_and_o(src0_ready_and_o), .src0_rd_addr_i(src0_rd_addr_i),
    .src0_ird_w_v_i(src0_ird_w_v_i), .src0_frd_w_v_i(src0_frd_w_v_i), .src0_ptw_w_v_i(src0_ptw_w_v_i),
    .src0_data_i(src0_data_i), .src0_fflags_i(src0_fflags_i),
    .src1_v_i(src1_v_i), .src1_ready_and_o(src1_ready_and_o), .src1_rd_addr_i(src1_rd_addr_i),
    .src1_ird_w_v_i(src1_ird_w_v_i), .src1_frd_w_v_i(src1_frd_w_v_i), .src1_ptw_w_v_i(src1_ptw_w_v_i),
    .src1_data_i(src1_data_i), .src1_fflags_i(src1_fflags_i),
    .late_wb_v_o(late_wb_v_o), .late_wb_force_o(late_wb_force_o), .late_wb_yumi_i(late_wb_yumi_i),
    .late_wb_rd_addr_o(late_wb_rd_addr_o), .late_wb_ird_w_v_o(late_wb_ird_w_v_o),
    .late_wb_frd_w_v_o(late_wb_frd_w_v_o), .late_wb_ptw_w_v_o(late_wb_ptw_w_v_o),
    .late_wb_data_o(late_wb_data_o), .late_wb_fflags_o(late_wb_fflags_o),
    .irf_pending_o(irf_pending_o), .frf_pending_o(frf_pending_o)
  );

  // Monitor: every consumed head must match the next expected entry.
  always @(negedge clk_i) begin
    if (late_wb_v_o && late_wb_yumi_i) begin
      mon_act = '{rd: late_wb_rd_addr_o, ird: late_wb_ird_w_v_o, frd: late_wb_frd_w_v_o,
                  ptw: late_wb_ptw_w_v_o, data: late_wb_data_o, ff: late_wb_fflags_o};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h required=no entry", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL sb_pkt actual=0x%0h required=0x%0h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic ent_t mk(input logic [4:0] rd, input logic ird, input logic frd,
                              input logic ptw, input logic [63:0] data, input logic [4:0] ff);
    return '{rd: rd, ird: ird, frd: frd, ptw: ptw, data: data, ff: ff};
  endfunction

  task automatic drv0(input ent_t e);
    src0_v_i = 1'b1; src0_rd_addr_i = e.rd; src0_ird_w_v_i = e.ird; src0_frd_w_v_i = e.frd;
    src0_ptw_w_v_i = e.ptw; src0_data_i = e.data; src0_fflags_i = e.ff;
  endtask

  task automatic drv1(input ent_t e);
    src1_v_i = 1'b1; src1_rd_addr_i = e.rd; src1_ird_w_v_i = e.ird; src1_frd_w_v_i = e.frd;
    src1_ptw_w_v_i = e.ptw; src1_data_i = e.data; src1_fflags_i = e.ff;
  endtask

  task automatic idle;
    src0_v_i = 1'b0;
    src1_v_i = 1'b0;
  endtask

  initial begin
    ent_t e0, e1, e2, e3, e4, ex;
    reset_n_i = 1'b0; late_wb_yumi_i = 1'b0;
    drv0('0); drv1('0); idle();

    tick();
    chk("rst_rdy0", src0_ready_and_o, 0);
    chk("rst_rdy1", src1_ready_and_o, 0);
    chk("rst_v", late_wb_v_o, 0);
    chk("rst_irf", irf_pending_o, 0);
    reset_n_i = 1'b1;
    #1;
    chk("post_rst_rdy0", src0_ready_and_o, 1);
    chk("post_rst_rdy1", src1_ready_and_o, 1);

    // Single enqueue x5 <- 0x1234
    e0 = mk(5'd5, 1, 0, 0, 64'h1234, 5'd0);
    drv0(e0); exp_q.push_back(e0);
    tick(); idle();
    chk("single_v", late_wb_v_o, 1);
    chk("single_rd", late_wb_rd_addr_o, 5);
    chk("single_data", late_wb_data_o, 64'h1234);
    chk("single_irf", irf_pending_o, 32'h20);
    chk("single_force", late_wb_force_o, 0);
    late_wb_yumi_i = 1'b1;
    tick(); late_wb_yumi_i = 1'b0;
    chk("single_v_after", late_wb_v_o, 0);
    chk("single_irf_after", irf_pending_o, 0);
    chk("single_data_zero", late_wb_data_o, 0);

    // Dual enqueue: src1 (f7) lands ahead of src0 (x3)
    e0 = mk(5'd3, 1, 0, 0, 64'hAAAA_0003, 5'd0);
    e1 = mk(5'd7, 0, 1, 0, 64'hBBBB_0007, 5'h05);
    drv0(e0); drv1(e1); exp_q.push_back(e1); exp_q.push_back(e0);
    tick(); idle();
    chk("dual_irf", irf_pending_o, 32'h8);
    chk("dual_frf", frf_pending_o, 32'h80);
    chk("dual_head_rd", late_wb_rd_addr_o, 7);
    chk("dual_head_frd", late_wb_frd_w_v_o, 1);
    late_wb_yumi_i = 1'b1;
    tick();
    chk("dual_second_rd", late_wb_rd_addr_o, 3);
    chk("dual_frf_after", frf_pending_o, 0);
    tick(); late_wb_yumi_i = 1'b0;
    chk("dual_empty", late_wb_v_o, 0);

    // Fill to 4 entries, including a PTW return
    e0 = mk(5'd11, 1, 0, 0, 64'hA0, 5'd0);
    e1 = mk(5'd12, 1, 0, 0, 64'hA1, 5'd0);
    e2 = mk(5'd14, 0, 1, 0, 64'hA2, 5'h1f);
    e3 = mk(5'd13, 0, 0, 1, 64'hDEAD_BEEF_0000_0013, 5'd0);
    drv0(e0); drv1(e1); exp_q.push_back(e1); exp_q.push_back(e0);
    tick();
    drv0(e2); drv1(e3); exp_q.push_back(e3); exp_q.push_back(e2);
    tick(); idle();
    #1;
    chk("full_rdy0", src0_ready_and_o, 0);
    chk("full_rdy1", src1_ready_and_o, 0);
    chk("full_force", late_wb_force_o, 1);
    late_wb_yumi_i = 1'b1;
    tick(); late_wb_yumi_i = 1'b0;
    #1;
    chk("cnt3_rdy1_idle", src1_ready_and_o, 1);
    e4 = mk(5'd15, 1, 0, 0, 64'hA4, 5'd0);
    ex = mk(5'd16, 1, 0, 0, 64'hBAD, 5'd0);
    drv0(ex); drv1(e4); exp_q.push_back(e4);
    #1;
    chk("cnt3_rdy0_both", src0_ready_and_o, 0);
    chk("cnt3_rdy1_both", src1_ready_and_o, 1);
    tick(); idle();
    #1;
    chk("refull_force", late_wb_force_o, 1);
    chk("refull_rdy0", src0_ready_and_o, 0);
    late_wb_yumi_i = 1'b1;
    repeat (4) tick();
    late_wb_yumi_i = 1'b0;
    chk("drain_v", late_wb_v_o, 0);

    // Aging: force asserts 8 cycles after the entry becomes visible
    e0 = mk(5'd10, 1, 0, 0, 64'h5A5A, 5'd0);
    drv1(e0); exp_q.push_back(e0);
    tick(); idle();
    chk("age_force_0", late_wb_force_o, 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("age_force_pre", late_wb_force_o, 0);
    end
    tick();
    chk("age_force_8", late_wb_force_o, 1);
    late_wb_yumi_i = 1'b1;
    tick(); late_wb_yumi_i = 1'b0;
    chk("age_force_clr", late_wb_force_o, 0);

    // x0 never pending; duplicate x9 entries
    e0 = mk(5'd0, 1, 0, 0, 64'h0, 5'd0);
    e1 = mk(5'd9, 1, 0, 0, 64'h9001, 5'd0);
    e2 = mk(5'd9, 1, 0, 0, 64'h9002, 5'd0);
    drv0(e0); drv1(e1); exp_q.push_back(e1); exp_q.push_back(e0);
    tick(); idle();
    chk("x0_irf", irf_pending_o, 32'h200);
    chk("fresh_age_force", late_wb_force_o, 0);
    drv0(e2); exp_q.push_back(e2);
    tick(); idle();
    chk("dup_irf_3", irf_pending_o, 32'h200);
    late_wb_yumi_i = 1'b1;
    tick();
    chk("dup_irf_2", irf_pending_o, 32'h200);
    tick();
    chk("dup_irf_1", irf_pending_o, 32'h200);
    tick(); late_wb_yumi_i = 1'b0;
    chk("dup_irf_0", irf_pending_o, 0);

    // Asynchronous reset with 3 entries held
    e0 = mk(5'd2, 1, 0, 0, 64'h22, 5'd0);
    e1 = mk(5'd1, 0, 1, 0, 64'h11, 5'd3);
    e2 = mk(5'd4, 1, 0, 0, 64'h44, 5'd0);
    drv0(e0); drv1(e1);
    tick(); idle();
    drv0(e2);
    tick(); idle();
    chk("held_irf", irf_pending_o, 32'h14);
    chk("held_frf", frf_pending_o, 32'h2);
    chk("held_head_data", late_wb_data_o, 64'h11);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("arst_v", late_wb_v_o, 0);
    chk("arst_irf", irf_pending_o, 0);
    chk("arst_frf", frf_pending_o, 0);
    chk("arst_data", late_wb_data_o, 0);
    chk("arst_force", late_wb_force_o, 0);
    chk("arst_rdy0", src0_ready_and_o, 0);
    chk("arst_rdy1", src1_ready_and_o, 0);
    tick();
    reset_n_i = 1'b1;
    #1;
    chk("rel_rdy0", src0_ready_and_o, 1);
    chk("rel_rdy1", src1_ready_and_o, 1);
    chk("rel_v", late_wb_v_o, 0);

    tick(); tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
